// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_unit_pkg;

  localparam int unsigned INST_ADDR_BUS = 32;
  localparam int unsigned INST_DATA_BUS = 32;

  localparam logic [INST_ADDR_BUS-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [INST_DATA_BUS-1:0] INST_NOP         = 32'h0000_0013;

  localparam logic RST_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StWait = 2'd1,
    StOut  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage connections: redirect input, imem request/response and decode-side buffer.
interface inst_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_resp_valid;
  logic [DATA_W-1:0] imem_resp_data;
  logic              imem_resp_err;
  logic              inst_valid;
  logic              inst_ready;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] inst;
  logic              inst_fault;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data,
           imem_resp_err, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, pc, inst, inst_fault
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data,
           imem_resp_err, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, pc, inst, inst_fault
  );
endinterface

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: reset vector, word-aligned redirect load and +4 advance.
module fetch_pc_reg
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = INST_ADDR_BUS,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              incr_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid_i) begin
      pc_q <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
    end else if (incr_i) begin
      pc_q <= pc_q + ADDR_W'(4);
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, single-entry output buffer to decode,
// with redirect-driven squashing of stale responses.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = INST_ADDR_BUS,
  parameter int unsigned       DATA_W   = INST_DATA_BUS,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input logic                clk,
  input logic                rst,
  inst_fetch_unit_if.master  bus
);

  fetch_state_e      state_q;
  logic              drop_q;
  logic              inst_valid_q;
  logic              fault_q;
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] pc_out_q;
  logic [ADDR_W-1:0] pc;
  logic              req_valid;
  logic              req_fire;
  logic              pc_incr;

  assign req_valid = (state_q == StReq) && (rst != RST_ENABLE);
  assign req_fire  = req_valid && bus.imem_req_ready;
  // A redirect in the accept cycle still consumes the entry but suppresses the +4.
  assign pc_incr   = (state_q == StOut) && bus.inst_ready && !bus.redirect_valid;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (bus.redirect_valid),
    .redirect_pc_i    (bus.redirect_pc),
    .incr_i           (pc_incr),
    .pc_o             (pc)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q      <= StReq;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      inst_q       <= DATA_W'(INST_NOP);
      pc_out_q     <= RESET_PC;
    end else begin
      case (state_q)
        StReq: begin
          if (req_fire) begin
            state_q <= StWait;
            // Request already left with the old pc; squash whatever comes back.
            if (bus.redirect_valid) drop_q <= 1'b1;
          end
        end
        StWait: begin
          if (bus.imem_resp_valid) begin
            if (drop_q || bus.redirect_valid) begin
              drop_q  <= 1'b0;
              state_q <= StReq;
            end else begin
              inst_q       <= bus.imem_resp_err ? DATA_W'(INST_NOP) : bus.imem_resp_data;
              fault_q      <= bus.imem_resp_err;
              pc_out_q     <= pc;
              inst_valid_q <= 1'b1;
              state_q      <= StOut;
            end
          end else if (bus.redirect_valid) begin
            drop_q <= 1'b1;
          end
        end
        StOut: begin
          if (bus.redirect_valid || bus.inst_ready) begin
            inst_valid_q <= 1'b0;
            state_q      <= StReq;
          end
        end
        default: state_q <= StReq;
      endcase
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.pc             = pc_out_q;
  assign bus.inst           = inst_q;
  assign bus.inst_fault     = fault_q;

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction fetch stage directly upstream of the decode stage. It owns the PC register and issues one instruction-memory read at a time over a valid/ready request channel, then waits for a valid response. It holds each fetched instruction and its PC in an output buffer until decode accepts it. It also takes PC redirects from the control transfer unit and discards any in-flight or buffered instruction that a redirect makes stale.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction word width
RESET_PC, 32'h8000_0000, first fetch address after reset

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
redirect_valid_i  in  1  control transfer unit requests PC change this cycle
redirect_pc_i  in  ADDR_W  new fetch target
imem_req_valid_o  out  1  read request valid
imem_req_addr_o  out  ADDR_W  read address (word aligned)
imem_req_ready_i  in  1  memory accepts request
imem_resp_valid_i  in  1  response data valid
imem_resp_data_i  in  DATA_W  fetched word
imem_resp_err_i  in  1  access fault, qualified by imem_resp_valid_i
inst_valid_o  out  1  output buffer holds instruction for decode
inst_ready_i  in  1  decode accepts instruction
pc_o  out  ADDR_W  PC of buffered instruction (feeds decode pc_i)
inst_o  out  DATA_W  buffered instruction (feeds decode inst_i)
inst_fault_o  out  1  buffered entry came from an errored response

Behaviour:
- Reset (rst=1 at edge): state S_REQ, pc=RESET_PC, drop=0, imem_req_valid_o=0 while rst high, inst_valid_o=0, inst_o=32'h0000_0013 (NOP), inst_fault_o=0, pc_o=RESET_PC. Reset mid-transaction abandons everything; a late response after reset is ignored, since drop is cleared and the FSM is in S_REQ, which ignores responses.
- States:
  - S_REQ: imem_req_valid_o=1, addr=pc. On imem_req_ready_i go to S_WAIT.
  - S_WAIT: request outstanding, imem_req_valid_o=0. On imem_resp_valid_i:
    - drop=1 or redirect this cycle: discard the response, clear drop, go to S_REQ.
    - otherwise: load inst_o, pc_o=pc and inst_fault_o=imem_resp_err_i; go to S_OUT.
  - S_OUT: inst_valid_o=1; inst_o, pc_o and inst_fault_o are stable while not accepted. On inst_valid_o & inst_ready_i: pc<=pc+4 (mod 2^ADDR_W, wraps), go to S_REQ.
- Redirect (highest priority, any state):
  - pc<=redirect_pc_i with bits [1:0] forced to 0.
  - S_REQ: if request handshake happens in the same cycle, set drop=1 and go to S_WAIT; otherwise stay in S_REQ and the next request uses the new pc.
  - S_WAIT without a response this cycle: drop<=1, stay in S_WAIT.
  - S_OUT: inst_valid_o<=0, go to S_REQ. A simultaneous decode handshake still counts as consumed, and no pc+4 is applied.
  - A second redirect while drop=1 overwrites pc; drop stays 1.
- imem_req_addr_o must be stable while imem_req_valid_o=1 and ready=0, except when a redirect changes pc.
- At most one outstanding request. imem_resp_valid_i outside S_WAIT is ignored.
- Minimum latency: request accepted at cycle 0, response at cycle 1, inst_valid_o at cycle 2. Peak throughput is one instruction per 3 cycles.
- Errored response: inst_o=NOP and inst_fault_o=1. The PC still advances normally on acceptance.

Decomposition:
- Shared defines file:
  - State encodings S_REQ/S_WAIT/S_OUT.
  - INST_NOP 32'h0000_0013.
  - RESET_PC default.
  - INST_ADDR_BUS and INST_DATA_BUS widths.
  - RST_ENABLE.
- One sub-module, fetch_pc_reg, holds the PC with reset, redirect load, +4 increment and alignment masking. The FSM and output buffer stay in the top module.

Test Plan:
- Reset then memory with ready=1 and 1-cycle response 32'h0010_0093 -> req addr 0x8000_0000 at cycle 0; inst_valid_o=1 at cycle 2 with pc_o=0x8000_0000 and inst_o=0x0010_0093; after accept, next req addr 0x8000_0004.
- Decode holds inst_ready_i=0 for 5 cycles -> inst_o/pc_o unchanged, no new request issued; accept on cycle 6 -> request at 0x8000_0004 the next cycle.
- Redirect to 0x8000_0100 while in S_WAIT, response 32'hDEAD_BEEF arrives 3 cycles later -> response dropped, inst_valid_o stays 0, next request at 0x8000_0100.
- Redirect to 0x8000_0203 in the same cycle as decode accepts the instruction at 0x8000_0010 -> next request at 0x8000_0200, not 0x8000_0014.
- Response with imem_resp_err_i=1 -> inst_o=0x0000_0013, inst_fault_o=1; on acceptance, next request at pc+4.
- Assert rst in S_WAIT, then deliver a response one cycle after release -> response ignored, outputs at reset values, request reissued at 0x8000_0000.
